// File: rtl/parser_ctrl.sv
// Assembles big-endian ITCH stream words into seven message registers for the parser.
// Optional statistics counters are built only when PARSER_CTRL_STATS_EN is defined.
module parser_ctrl #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_sof,
    output logic                 o_ready,
    output logic [REG_WIDTH-1:0] o_reg_1,
    output logic [REG_WIDTH-1:0] o_reg_2,
    output logic [REG_WIDTH-1:0] o_reg_3,
    output logic [REG_WIDTH-1:0] o_reg_4,
    output logic [REG_WIDTH-1:0] o_reg_5,
    output logic [REG_WIDTH-1:0] o_reg_6,
    output logic [REG_WIDTH-1:0] o_reg_7,
    output logic                 o_msg_valid,
    input  logic                 i_msg_ready,
    output logic [15:0]          o_msg_count,
    output logic [15:0]          o_err_count
);

    localparam logic [7:0] TYPE_ADD    = 8'h41;
    localparam logic [7:0] TYPE_CANCEL = 8'h58;
    localparam logic [7:0] TYPE_EXEC   = 8'h45;

    typedef enum logic [1:0] {IDLE, LOAD, DISCARD, PRESENT} state_t;

    state_t               state_reg;
    logic [2:0]           word_cnt_reg;
    logic [2:0]           exp_len_reg;
    logic                 ready_reg;
    logic                 valid_reg;
    logic [REG_WIDTH-1:0] msg_reg [1:7];

    logic                 beat;
    logic                 restart;
    logic                 load_word;
    logic [7:0]           type_byte;
    logic [2:0]           sof_len;
    logic [2:0]           word_cnt_inc;

    // A zero length marks an unknown message type.
    always_comb begin
        type_byte = i_data[REG_WIDTH-1 -: 8];
        case (type_byte)
            TYPE_ADD:    sof_len = 3'd7;
            TYPE_CANCEL: sof_len = 3'd3;
            TYPE_EXEC:   sof_len = 3'd4;
            default:     sof_len = 3'd0;
        endcase
    end

    assign beat         = i_valid && ready_reg;
    assign restart      = beat && i_sof;
    assign load_word    = beat && !i_sof && (state_reg == LOAD);
    assign word_cnt_inc = word_cnt_reg + 3'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i <= 7; i++) msg_reg[i] <= '0;
        end else if (restart) begin
            msg_reg[1] <= i_data;
            for (int i = 2; i <= 7; i++) msg_reg[i] <= '0;
        end else if (load_word) begin
            for (int i = 2; i <= 7; i++)
                if (word_cnt_reg == 3'(i - 1)) msg_reg[i] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            word_cnt_reg <= 3'd0;
            exp_len_reg  <= 3'd0;
            ready_reg    <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                PRESENT: begin
                    if (i_msg_ready) begin
                        state_reg    <= IDLE;
                        word_cnt_reg <= 3'd0;
                        ready_reg    <= 1'b1;
                        valid_reg    <= 1'b0;
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    // A start-of-frame beat restarts assembly from any accepting state.
                    if (restart) begin
                        word_cnt_reg <= 3'd1;
                        exp_len_reg  <= sof_len;
                        state_reg    <= (sof_len != 3'd0) ? LOAD : DISCARD;
                    end else if (load_word) begin
                        word_cnt_reg <= word_cnt_inc;
                        if (word_cnt_inc == exp_len_reg) begin
                            state_reg <= PRESENT;
                            ready_reg <= 1'b0;
                            valid_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_ready     = ready_reg;
    assign o_msg_valid = valid_reg;
    assign o_reg_1     = msg_reg[1];
    assign o_reg_2     = msg_reg[2];
    assign o_reg_3     = msg_reg[3];
    assign o_reg_4     = msg_reg[4];
    assign o_reg_5     = msg_reg[5];
    assign o_reg_6     = msg_reg[6];
    assign o_reg_7     = msg_reg[7];

`ifdef PARSER_CTRL_STATS_EN
    logic [15:0] msg_cnt_reg;
    logic [15:0] err_cnt_reg;
    logic [1:0]  err_inc;
    logic        msg_inc;

    // An aborting start-of-frame with an unknown type costs two errors in one beat.
    always_comb begin
        err_inc = {1'b0, beat && !i_sof && (state_reg == IDLE)}
                + {1'b0, restart && (sof_len == 3'd0)}
                + {1'b0, restart && (state_reg == LOAD)};
        msg_inc = (state_reg == PRESENT) && i_msg_ready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            msg_cnt_reg <= 16'd0;
            err_cnt_reg <= 16'd0;
        end else begin
            if (msg_inc && msg_cnt_reg != 16'hFFFF)
                msg_cnt_reg <= msg_cnt_reg + 16'd1;
            if (err_cnt_reg > 16'hFFFF - {14'd0, err_inc})
                err_cnt_reg <= 16'hFFFF;
            else
                err_cnt_reg <= err_cnt_reg + {14'd0, err_inc};
        end
    end

    assign o_msg_count = msg_cnt_reg;
    assign o_err_count = err_cnt_reg;
`else
    assign o_msg_count = 16'd0;
    assign o_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_parser_ctrl.sv
// Randomised and directed checks of parser_ctrl against a message-level queue model.
// Counter expectations follow PARSER_CTRL_STATS_EN in the same way as the design.
module tb_parser_ctrl;

`ifdef PARSER_CTRL_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef bit [31:0] word_t;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_data;
    logic        i_valid;
    logic        i_sof;
    logic        o_ready;
    logic [31:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6, o_reg_7;
    logic        o_msg_valid;
    logic        i_msg_ready;
    logic [15:0] o_msg_count;
    logic [15:0] o_err_count;
    logic [31:0] dut_reg [1:7];

    parser_ctrl #(.REG_WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .o_ready     (o_ready),
        .o_reg_1     (o_reg_1),
        .o_reg_2     (o_reg_2),
        .o_reg_3     (o_reg_3),
        .o_reg_4     (o_reg_4),
        .o_reg_5     (o_reg_5),
        .o_reg_6     (o_reg_6),
        .o_reg_7     (o_reg_7),
        .o_msg_valid (o_msg_valid),
        .i_msg_ready (i_msg_ready),
        .o_msg_count (o_msg_count),
        .o_err_count (o_err_count)
    );

    assign dut_reg[1] = o_reg_1;
    assign dut_reg[2] = o_reg_2;
    assign dut_reg[3] = o_reg_3;
    assign dut_reg[4] = o_reg_4;
    assign dut_reg[5] = o_reg_5;
    assign dut_reg[6] = o_reg_6;
    assign dut_reg[7] = o_reg_7;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Message-level model: words collected so far, expected length, and counters.
    word_t m_words[$];
    int    m_len;       // 0 = waiting for a frame, -1 = discarding, >0 = collecting
    bit    m_present;
    bit    m_ready;
    int    m_msg;
    int    m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int len_of(input bit [7:0] t);
        case (t)
            8'h41:   return 7;
            8'h58:   return 3;
            8'h45:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_words.delete();
        m_len     = 0;
        m_present = 0;
        m_ready   = 0;
        m_msg     = 0;
        m_err     = 0;
    endfunction

    function automatic void add_err();
        if (m_err < 65535) m_err++;
    endfunction

    function automatic void model_step();
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        if (m_present) begin
            if (i_msg_ready) begin
                if (m_msg < 65535) m_msg++;
                $display("msg presented: type %h, %0d words", m_words[0][31:24], m_words.size());
                m_present = 0;
                m_len     = 0;
            end
        end else if (m_ready && i_valid) begin
            if (i_sof) begin
                if (m_len > 0) add_err();
                m_words.delete();
                m_words.push_back(i_data);
                m_len = len_of(i_data[31:24]);
                if (m_len == 0) begin
                    add_err();
                    m_len = -1;
                end
            end else if (m_len == 0) begin
                add_err();
            end else if (m_len > 0) begin
                m_words.push_back(i_data);
                if (m_words.size() == m_len) m_present = 1;
            end
        end
        m_ready = !m_present;
    endfunction

    task automatic check_outputs();
        word_t exp;
        chk("ready", {31'd0, o_ready}, {31'd0, m_ready});
        chk("msg_valid", {31'd0, o_msg_valid}, {31'd0, m_present});
        for (int k = 1; k <= 7; k++) begin
            exp = (k <= m_words.size()) ? m_words[k-1] : 32'd0;
            chk($sformatf("reg_%0d", k), dut_reg[k], exp);
        end
        chk("msg_count", {16'd0, o_msg_count}, 32'(STATS * m_msg));
        chk("err_count", {16'd0, o_err_count}, 32'(STATS * m_err));
    endtask

    task automatic drive_cycle(input bit v, input bit s, input word_t d, input bit mr);
        @(negedge i_clk);
        check_outputs();
        i_valid     = v;
        i_sof       = s;
        i_data      = d;
        i_msg_ready = mr;
        @(posedge i_clk);
        model_step();
    endtask

    task automatic send(input bit s, input word_t d, input bit mr);
        bit was;
        int n = 0;
        do begin
            was = m_ready;
            drive_cycle(1'b1, s, d, mr);
            n++;
        end while (!was && n < 20);
        if (!was) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input bit mr);
        repeat (n) drive_cycle(1'b0, 1'b0, 32'd0, mr);
    endtask

    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        idle(2, 1'b0);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t w;
        bit [7:0] types [5];
        types[0] = 8'h41; types[1] = 8'h58; types[2] = 8'h45; types[3] = 8'h5A; types[4] = 8'h00;

        i_rst_n = 1'b1; i_valid = 0; i_sof = 0; i_data = 0; i_msg_ready = 0;
        model_reset();
        do_reset();

        // Add: seven words, downstream ready.
        send(1, 32'h41000300, 1);
        for (int i = 2; i <= 7; i++) send(0, 32'hA0000000 + 32'(i), 1);
        #1;
        chk("add_valid", {31'd0, o_msg_valid}, 32'd1);
        chk("add_reg1", o_reg_1, 32'h41000300);
        chk("add_reg7", o_reg_7, 32'hA0000007);
        idle(1, 1);
        #1;
        chk("add_valid_drop", {31'd0, o_msg_valid}, 32'd0);
        chk("add_msg_count", {16'd0, o_msg_count}, 32'(STATS));

        // Cancel: three words, upper registers cleared.
        send(1, 32'h58123456, 1);
        send(0, 32'hB0000002, 1);
        send(0, 32'hB0000003, 1);
        #1;
        chk("cancel_valid", {31'd0, o_msg_valid}, 32'd1);
        chk("cancel_reg3", o_reg_3, 32'hB0000003);
        chk("cancel_reg4", o_reg_4, 32'd0);
        chk("cancel_reg7", o_reg_7, 32'd0);
        idle(1, 1);

        // Execute held by backpressure for five cycles.
        send(1, 32'h45ABCDEF, 0);
        for (int i = 2; i <= 4; i++) send(0, 32'hC0000000 + 32'(i), 0);
        idle(5, 0);
        #1;
        chk("bp_valid", {31'd0, o_msg_valid}, 32'd1);
        chk("bp_ready", {31'd0, o_ready}, 32'd0);
        chk("bp_reg1", o_reg_1, 32'h45ABCDEF);
        idle(1, 1);
        #1;
        chk("bp_release_valid", {31'd0, o_msg_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, o_ready}, 32'd1);

        // Abort: Add interrupted at beat 4 by an Execute frame.
        send(1, 32'h41000001, 1);
        send(0, 32'hD0000002, 1);
        send(0, 32'hD0000003, 1);
        send(1, 32'h45000001, 1);
        for (int i = 2; i <= 4; i++) send(0, 32'hE0000000 + 32'(i), 1);
        #1;
        chk("abort_valid", {31'd0, o_msg_valid}, 32'd1);
        chk("abort_reg1", o_reg_1, 32'h45000001);
        chk("abort_err", {16'd0, o_err_count}, 32'(STATS));
        idle(1, 1);

        // Unknown type dropped, following Cancel presented.
        send(1, 32'h5A000000, 1);
        send(0, 32'hF0000002, 1);
        send(0, 32'hF0000003, 1);
        #1;
        chk("unk_valid", {31'd0, o_msg_valid}, 32'd0);
        send(1, 32'h58000077, 1);
        send(0, 32'h11111111, 1);
        send(0, 32'h22222222, 1);
        #1;
        chk("unk_cancel_valid", {31'd0, o_msg_valid}, 32'd1);
        chk("unk_cancel_reg1", o_reg_1, 32'h58000077);
        chk("unk_err", {16'd0, o_err_count}, 32'(2 * STATS));
        idle(1, 1);
        #1;
        chk("unk_msg_count", {16'd0, o_msg_count}, 32'(5 * STATS));

        // Reset in the middle of an Add, then a clean Add.
        send(1, 32'h41000555, 1);
        send(0, 32'h33333333, 1);
        send(0, 32'h44444444, 1);
        do_reset();
        send(1, 32'h41000666, 1);
        for (int i = 2; i <= 7; i++) send(0, 32'h55000000 + 32'(i), 1);
        #1;
        chk("rst_add_reg1", o_reg_1, 32'h41000666);
        chk("rst_add_reg2", o_reg_2, 32'h55000002);
        idle(1, 1);
        #1;
        chk("rst_add_msg_count", {16'd0, o_msg_count}, 32'(STATS));

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            bit v, s, mr;
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 4) == 0);
            mr = ($urandom_range(0, 9) < 7);
            w  = $urandom();
            if (s) w[31:24] = (types[$urandom_range(0, 4)] == 8'h00) ? 8'($urandom()) : types[$urandom_range(0, 3)];
            if ($urandom_range(0, 399) == 0) do_reset();
            else drive_cycle(v, s, w, mr);
        end
        idle(2, 1);
        @(negedge i_clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
